// File: rtl/ysyx_25030077_operand_stage.sv
// Registered ALU operand-select stage with a valid/ready handshake and one-entry skid buffer.
// Optional writeback forwarding into rs1/rs2 is enabled by defining OPSEL_FWD_EN.
module ysyx_25030077_operand_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned SEL_W  = 3,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [REG_AW-1:0] in_rs1_idx,
    input  logic [REG_AW-1:0] in_rs2_idx,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_mem_data,
    input  logic              fwd_valid,
    input  logic [REG_AW-1:0] fwd_rd,
    input  logic [XLEN-1:0]   fwd_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data_1,
    output logic [XLEN-1:0]   out_data_2
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] out1_q, out1_d, out2_q, out2_d;
    logic [XLEN-1:0] skid1_q, skid1_d, skid2_q, skid2_d;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [XLEN-1:0] op1, op2;
    logic            accept;

`ifdef OPSEL_FWD_EN
    // Index 0 is the hardwired zero register and is never forwarded.
    assign rs1_val = (fwd_valid && (fwd_rd == in_rs1_idx) && (in_rs1_idx != '0)) ? fwd_data : in_rs1_data;
    assign rs2_val = (fwd_valid && (fwd_rd == in_rs2_idx) && (in_rs2_idx != '0)) ? fwd_data : in_rs2_data;
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_valid, fwd_rd, fwd_data, in_rs1_idx, in_rs2_idx};
    assign rs1_val    = in_rs1_data;
    assign rs2_val    = in_rs2_data;
`endif

    always_comb begin
        op1 = rs1_val;
        op2 = in_imm;
        case (in_sel)
            SEL_W'(1): begin op1 = in_pc;       op2 = in_imm;     end
            SEL_W'(2): begin op1 = in_mem_data; op2 = '0;         end
            SEL_W'(3): begin op1 = rs1_val;     op2 = rs2_val;    end
            SEL_W'(4): begin op1 = in_pc;       op2 = XLEN'(4);   end
            SEL_W'(5): begin op1 = '0;          op2 = in_imm;     end
            default:   begin op1 = rs1_val;     op2 = in_imm;     end
        endcase
    end

    assign in_ready   = reset && (state_q != ST_FULL);
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state_q != ST_EMPTY);
    assign out_data_1 = out1_q;
    assign out_data_2 = out2_q;

    always_comb begin
        state_d = state_q;
        out1_d  = out1_q;
        out2_d  = out2_q;
        skid1_d = skid1_q;
        skid2_d = skid2_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        out1_d  = op1;
                        out2_d  = op2;
                    end
                end
                ST_ONE: begin
                    if (out_ready && accept) begin
                        out1_d = op1;
                        out2_d = op2;
                    end else if (out_ready) begin
                        state_d = ST_EMPTY;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        skid1_d = op1;
                        skid2_d = op2;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        state_d = ST_ONE;
                        out1_d  = skid1_q;
                        out2_d  = skid2_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            out1_q  <= '0;
            out2_q  <= '0;
            skid1_q <= '0;
            skid2_q <= '0;
        end else begin
            state_q <= state_d;
            out1_q  <= out1_d;
            out2_q  <= out2_d;
            skid1_q <= skid1_d;
            skid2_q <= skid2_d;
        end
    end

endmodule
